// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch unit.
// Optional perf counters in the top are enabled with IF_PERF_CNT_EN.
package FetchPkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 6;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  // Branch displacement: sign-extended 16-bit word offset turned into bytes
  function automatic logic [XLEN-1:0] sext_imm16_x4(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_npc_calc.sv
// Next-PC selection for the held instruction: jump beats a taken beq,
// otherwise sequential. All arithmetic wraps modulo 2^32.
module npc_calc
  import FetchPkg::*;
(
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] instr,
  input  logic            is_beq,
  input  logic            jmp,
  input  logic            alu_zero,
  output logic [XLEN-1:0] next_pc
);

  // Opcode bits are decoded elsewhere; they take no part in target formation
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^instr[31:26];

  always_comb begin
    next_pc = pc_plus4;
    if (jmp) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (is_beq && alu_zero) begin
      next_pc = pc_plus4 + sext_imm16_x4(instr[15:0]);
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Multi-cycle instruction fetch: FETCH/WAIT request the word at pc, HOLD
// presents it until exec_done. Define IF_PERF_CNT_EN for retire/wait counters.
module if_fetch_unit
  import FetchPkg::*;
(
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ready,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic [XLEN-1:0]  instr,
  output logic [OPC_W-1:0] opcode,
  output logic             instr_valid,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  input  logic             is_beq,
  input  logic             jmp,
  input  logic             alu_zero,
  input  logic             exec_done
`ifdef IF_PERF_CNT_EN
  ,
  output logic [XLEN-1:0]  retired_cnt,
  output logic [XLEN-1:0]  wait_cnt
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] next_pc;

  npc_calc u_npc_calc (
    .pc_plus4 (pc_plus4_q),
    .instr    (instr_q),
    .is_beq   (is_beq),
    .jmp      (jmp),
    .alu_zero (alu_zero),
    .next_pc  (next_pc)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      FETCH, WAIT: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = HOLD;
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        if (exec_done) begin
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
    pc_plus4_d = pc_d + XLEN'(4);
    valid_d    = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      pc_plus4_q <= RESET_PC + XLEN'(4);
      instr_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  // Request is a state decode, masked while reset is held
  assign imem_req    = (state_q != HOLD) && !rst;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_q;

`ifdef IF_PERF_CNT_EN
  logic [XLEN-1:0] retired_q, retired_d;
  logic [XLEN-1:0] wait_q, wait_d;

  always_comb begin
    retired_d = retired_q;
    wait_d    = wait_q;
    if ((state_q == HOLD) && exec_done) begin
      retired_d = retired_q + XLEN'(1);
    end
    if ((state_q == WAIT) && !imem_ready) begin
      wait_d = wait_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      wait_q    <= '0;
    end else begin
      retired_q <= retired_d;
      wait_q    <= wait_d;
    end
  end

  assign retired_cnt = retired_q;
  assign wait_cnt    = wait_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized and directed bench for if_fetch_unit against a transaction-level
// model of held instruction, pc and request behaviour.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, imem_ready, is_beq, jmp, alu_zero, exec_done;
  logic [31:0] imem_rdata;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc, pc_plus4;
  logic [5:0]  opcode;
`ifdef IF_PERF_CNT_EN
  logic [31:0] retired_cnt, wait_cnt;
`endif

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .is_beq      (is_beq),
    .jmp         (jmp),
    .alu_zero    (alu_zero),
    .exec_done   (exec_done)
`ifdef IF_PERF_CNT_EN
    ,
    .retired_cnt (retired_cnt),
    .wait_cnt    (wait_cnt)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: an instruction is either held (m_valid) or being requested from m_pc
  logic [31:0] m_pc, m_instr, m_ret, m_wait;
  bit          m_valid, m_first;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [31:0] model_npc(input logic [31:0] p, input logic [31:0] ins,
                                            input bit b, input bit j, input bit z);
    logic [31:0] p4, off;
    p4 = p + 32'd4;
    if (j) return {p4[31:28], ins[25:0], 2'b00};
    off = {{16{ins[15]}}, ins[15:0]};
    if (b && z) return p4 + off * 32'd4;
    return p4;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h0; m_valid = 0; m_first = 1; m_ret = 0; m_wait = 0;
    end else if (!m_valid) begin
      if (!m_first && !imem_ready) m_wait = m_wait + 32'd1;
      m_first = 0;
      if (imem_ready) begin
        m_instr = imem_rdata;
        m_valid = 1;
      end
    end else if (exec_done) begin
      m_pc    = model_npc(m_pc, m_instr, is_beq, jmp, alu_zero);
      m_valid = 0;
      m_first = 1;
      m_ret   = m_ret + 32'd1;
    end
  endtask

  task automatic check_all();
    chk("imem_req", 32'(imem_req), 32'(!m_valid && !rst));
    if (!m_valid) chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("instr", instr, m_instr);
    chk("opcode", 32'(opcode), 32'(m_instr[31:26]));
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
`ifdef IF_PERF_CNT_EN
    chk("retired_cnt", retired_cnt, m_ret);
    chk("wait_cnt", wait_cnt, m_wait);
`endif
  endtask

  // One clock: drive at negedge, advance model at posedge, compare at next negedge
  task automatic cyc(input bit r, input bit rdy, input logic [31:0] rd,
                     input bit ex, input bit b, input bit j, input bit z);
    rst = r; imem_ready = rdy; imem_rdata = rd; exec_done = ex;
    is_beq = b; jmp = j; alu_zero = z;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  // Fetch one word with 'lows' ready-low cycles, then retire it
  task automatic run_instr(input logic [31:0] rd, input int lows,
                           input bit b, input bit j, input bit z);
    logic [31:0] a;
    a = imem_addr;
    for (int i = 0; i < lows; i++) begin
      cyc(0, 0, $urandom, 1, 1, 1, 1);
      chk("wait_no_valid", 32'(instr_valid), 32'd0);
      chk("wait_addr_hold", imem_addr, a);
    end
    cyc(0, 1, rd, 0, 0, 0, 0);
    chk("fetched_valid", 32'(instr_valid), 32'd1);
    cyc(0, 1, $urandom, 1, b, j, z);
  endtask

  logic [31:0] beq_m2, jmp_0x20;

  initial begin
    beq_m2   = {6'h04, 10'h0, 16'hFFFE};
    jmp_0x20 = {6'h02, 26'h000_0008};
    rst = 1; imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
    exec_done = 0; is_beq = 0; jmp = 0; alu_zero = 0;
    @(negedge clk);
    cyc(1, 1, 32'hDEAD_BEEF, 1, 0, 0, 0);
    cyc(1, 1, 32'hCAFE_F00D, 0, 0, 0, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    rst = 0;
    #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);

    // Zero-wait sequential fetch
    for (int k = 0; k < 4; k++) begin
      chk("seq_addr", imem_addr, 32'(k * 4));
      run_instr($urandom, 0, 0, 0, 0);
    end
    chk("seq_addr_0x10", imem_addr, 32'h10);

    // Wait states at 0x10
    run_instr($urandom, 4, 0, 0, 0);
`ifdef IF_PERF_CNT_EN
    chk("wait_cnt_3", wait_cnt, 32'd3);
`endif

    // Taken / not-taken beq at 0x20
    run_instr(jmp_0x20, 0, 0, 1, 0);
    chk("jmp_to_0x20", imem_addr, 32'h20);
    run_instr(beq_m2, 0, 1, 0, 1);
    chk("beq_taken", imem_addr, 32'h1C);
    run_instr(jmp_0x20, 0, 0, 1, 0);
    chk("jmp_back_0x20", imem_addr, 32'h20);
    run_instr(beq_m2, 1, 1, 0, 0);
    chk("beq_not_taken", imem_addr, 32'h24);

    // Reset while waiting at 0x30 with a response arriving
    for (int k = 0; k < 3; k++) run_instr($urandom | 32'h1, 0, 0, 0, 0);
    chk("addr_0x30", imem_addr, 32'h30);
    cyc(0, 0, $urandom, 0, 0, 0, 0);
    cyc(0, 0, $urandom, 0, 0, 0, 0);
    cyc(1, 1, 32'h1234_5678, 1, 0, 0, 0);
    chk("midwait_rst_pc", pc, 32'h0);
    chk("midwait_rst_instr", instr, 32'h0);
    chk("midwait_rst_valid", 32'(instr_valid), 32'd0);
    rst = 0;
    #1;
    chk("midwait_next_req", 32'(imem_req), 32'd1);
    chk("midwait_next_addr", imem_addr, 32'h0);

    // Wrap: branch back to 0xFFFF_FFFC, then fall through to 0
    run_instr(beq_m2, 0, 1, 0, 1);
    chk("to_top", imem_addr, 32'hFFFF_FFFC);
    run_instr($urandom, 0, 0, 0, 0);
    chk("wrap_zero", imem_addr, 32'h0);

    // Walk backwards through the address space into the 0x8xxx_xxxx region
    for (int i = 0; i < 20000 && m_pc[31:28] != 4'h8; i++)
      run_instr({6'h04, 10'h0, 16'h8000}, 0, 1, 0, 1);
    chk("region_8", 32'(m_pc[31:28]), 32'h8);
    run_instr({6'h02, 26'h000_0010}, 0, 0, 1, 0);
    chk("addr_8000_0040", imem_addr, 32'h8000_0040);
    run_instr({6'h02, 26'h000_0100}, 0, 1, 1, 1);
    chk("jmp_beats_beq", imem_addr, 32'h8000_0400);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0), $urandom,
          1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL provide clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL provide rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL provide imem_req, output, 1, instruction-memory read request.
REQ-004 SHALL provide imem_addr, output, 32, word-aligned fetch address.
REQ-005 SHALL provide imem_ready, input, 1, memory response valid this cycle.
REQ-006 SHALL provide imem_rdata, input, 32, instruction word, sampled when imem_ready=1.
REQ-007 SHALL provide instr, output, 32, registered instruction held for the decode/execute stage.
REQ-008 SHALL provide opcode, output, 6, equal to instr[31:26], for the main control decoder.
REQ-009 SHALL provide instr_valid, output, 1, instr/pc stable and executable.
REQ-010 SHALL provide pc and pc_plus4, outputs, 32 each, address of the held instr and that address + 4.
REQ-011 SHALL provide is_beq, jmp, alu_zero, inputs, 1 each, from the control decoder and ALU.
REQ-012 SHALL provide exec_done, input, 1, pulse meaning the held instruction has completed.

Function
REQ-013 SHALL implement FSM states FETCH, WAIT, HOLD.
REQ-014 SHALL, in FETCH, assert imem_req=1 and imem_addr=pc for one cycle, then go to WAIT.
REQ-015 SHALL, in WAIT, keep imem_req=1 and imem_addr=pc, and go to HOLD with instr<=imem_rdata when imem_ready=1.
REQ-016 SHALL accept imem_ready in the FETCH cycle itself: capture instr and go directly to HOLD (zero-wait memory).
REQ-017 SHALL assert instr_valid only in HOLD; imem_req SHALL be 0 in HOLD.
REQ-018 SHALL, in HOLD with exec_done=1, load pc<=next_pc and go to FETCH; without exec_done, remain in HOLD with instr and pc unchanged.
REQ-019 SHALL compute next_pc as follows, with jmp taking priority over a taken beq when both are asserted:
  - jmp=1: {pc_plus4[31:28], instr[25:0], 2'b00}
  - is_beq=1 and alu_zero=1: pc_plus4 + (sign-extended instr[15:0] << 2)
  - otherwise: pc_plus4
REQ-020 SHALL perform all address arithmetic modulo 2^32; wrap past 32'hFFFF_FFFC is silent.
REQ-021 SHALL ignore exec_done outside HOLD.
REQ-022 SHALL ignore imem_ready in HOLD.
REQ-023 SHALL drive opcode combinationally from instr.

Reset
REQ-024 SHALL, on rst=1, set pc=RESET_PC (32'h0000_0000), instr=0, state=FETCH, instr_valid=0, imem_req=0.
REQ-025 SHALL let rst override every other input, including mid-WAIT; a memory response arriving during reset SHALL be discarded.
REQ-026 SHALL issue the first fetch of RESET_PC in the first cycle after rst deasserts.

Configuration
REQ-027 SHALL, with IF_PERF_CNT_EN defined, add outputs retired_cnt[31:0] (increments on each exec_done accepted in HOLD) and wait_cnt[31:0] (increments on each WAIT cycle with imem_ready=0); both clear on rst and wrap modulo 2^32.
REQ-028 SHALL, without IF_PERF_CNT_EN, omit both ports and counters entirely.

Structure
REQ-029 SHALL place the state enum (FETCH/WAIT/HOLD) and RESET_PC in shared package FetchPkg.
REQ-030 SHALL implement the REQ-019 next-PC logic in combinational sub-module npc_calc (inputs pc_plus4, instr, is_beq, jmp, alu_zero; output next_pc).

Verification
REQ-031 Zero-wait sequential fetch: imem_ready=1 always, exec_done each HOLD -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid high one cycle per instruction.
REQ-032 Wait states: imem_ready delayed 3 cycles at pc=0x10 -> instr_valid stays 0 throughout; imem_addr holds 0x10; wait_cnt=3 with IF_PERF_CNT_EN.
REQ-033 Taken beq: pc=0x20, instr[15:0]=16'hFFFE, is_beq=1, alu_zero=1 -> next fetch 0x1C. Not taken (alu_zero=0) -> next fetch 0x24.
REQ-034 Jump: pc=0x8000_0040, instr[25:0]=26'h000_0100, jmp=1, is_beq=1, alu_zero=1 -> next fetch 0x8000_0400 (jump wins over the taken branch).
REQ-035 Reset mid-WAIT: rst asserted while waiting at pc=0x30 with imem_ready=1 in the same cycle -> state FETCH, pc=0, instr=0, next request to 0x0.
REQ-036 Wrap: pc=0xFFFF_FFFC, exec_done, no branch or jump -> next fetch 0x0000_0000.
